npc_pipe: RTL and testbench

Parametrised successor to the single-cycle next-PC logic: owns the architectural PC register and resolves sequential, conditional-branch, jump, jump-register, ERET and exception redirects each cycle. Sits at the fetch/decode boundary. The PC feeds IM. Decode supplies the control and operands for the instruction currently at `pc`. Branch conditions are evaluated internally, not taken from an ALU zero flag. It adds stall hold, exception priority and an optional MIPS branch-delay slot.

---
 rtl/npc_pkg.sv | 28 ++
 rtl/npc_br_cmp.sv | 36 +++
 rtl/npc_pipe.sv | 145 ++++++++++++++
 tb/tb_npc_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared encodings and default addresses for the next-PC block.
//   npc_op_e   : next-PC operation selected by decode (6-7 behave as SEQ).
//   br_cond_e  : branch condition selector (6-7 are never taken).
//   DEFAULT_RESET_PC / DEFAULT_EXC_VECTOR : default parameter values.
package npc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_J    = 3'd2,
        NPC_JAL  = 3'd3,
        NPC_JR   = 3'd4,
        NPC_ERET = 3'd5
    } npc_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LEZ = 3'd2,
        BR_GTZ = 3'd3,
        BR_LTZ = 3'd4,
        BR_GEZ = 3'd5
    } br_cond_e;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/npc_br_cmp.sv
// npc_br_cmp: combinational branch condition evaluator.
//   br_cond  in  3      condition selector (br_cond_e; 6-7 never taken)
//   rs_val   in  WIDTH  rs operand (signed for the compare-with-zero forms)
//   rt_val   in  WIDTH  rt operand (EQ/NE only)
//   cond     out 1      condition holds
module npc_br_cmp
    import npc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             cond
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_val[WIDTH-1];
    assign rs_zero = (rs_val == '0);

    always_comb begin
        cond = 1'b0;
        case (br_cond_e'(br_cond))
            BR_EQ:   cond = (rs_val == rt_val);
            BR_NE:   cond = (rs_val != rt_val);
            BR_LEZ:  cond = rs_neg | rs_zero;
            BR_GTZ:  cond = ~rs_neg & ~rs_zero;
            BR_LTZ:  cond = rs_neg;
            BR_GEZ:  cond = ~rs_neg;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/npc_pipe.sv
// npc_pipe: architectural PC register and next-PC resolution.
// Handles sequential flow, conditional branches, J/JAL, JR, ERET and
// exception entry, with stall hold. Defining NPC_DELAY_SLOT_EN builds a
// one-entry pending redirect that implements a MIPS branch-delay slot.
//   clk, rst_n      clock, asynchronous active-low reset
//   stall           hold PC and pending redirect
//   npc_op, br_cond decode control for the instruction at pc
//   rs_val, rt_val  operands (rs_val is also the JR target)
//   imm16, imm26    branch offset (words) / jump index
//   epc             ERET target
//   exc_req         take exception on this edge (overrides stall)
//   pc, pc_plus4    fetch PC and pc+4
//   link_addr       JAL return address
//   taken           current instruction redirects
//   in_delay_slot   current instruction sits in a delay slot
//   misalign        taken redirect target is not word aligned
module npc_pipe
    import npc_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       npc_op,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] epc,
    input  logic             exc_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] link_addr,
    output logic             taken,
    output logic             in_delay_slot,
    output logic             misalign
);

    logic             cond_hit;
    logic             raw_taken;
    logic             is_eret;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] target;

    npc_br_cmp #(
        .WIDTH (WIDTH)
    ) u_br_cmp (
        .br_cond (br_cond),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .cond    (cond_hit)
    );

    assign pc_plus4 = pc + WIDTH'(4);
    assign br_off   = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    assign is_eret  = (npc_op_e'(npc_op) == NPC_ERET);

    always_comb begin
        target    = pc_plus4;
        raw_taken = 1'b0;
        case (npc_op_e'(npc_op))
            NPC_BR: begin
                target    = pc_plus4 + br_off;
                raw_taken = cond_hit;
            end
            NPC_J, NPC_JAL: begin
                target    = {pc_plus4[WIDTH-1:28], imm26, 2'b00};
                raw_taken = 1'b1;
            end
            NPC_JR: begin
                target    = rs_val;
                raw_taken = 1'b1;
            end
            NPC_ERET: begin
                target    = epc;
                raw_taken = 1'b1;
            end
            default: begin
                target    = pc_plus4;
                raw_taken = 1'b0;
            end
        endcase
    end

    assign misalign = taken & (target[1:0] != 2'b00);

`ifdef NPC_DELAY_SLOT_EN
    logic             pend_v;
    logic [WIDTH-1:0] pend_t;

    // A control transfer sitting in a delay slot is ignored entirely.
    assign taken         = raw_taken & ~pend_v;
    assign in_delay_slot = pend_v;
    assign link_addr     = pc + WIDTH'(8);

    // ERET bypasses the pending register and redirects immediately;
    // every other taken redirect first steps into the delay slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            pend_v <= 1'b0;
            pend_t <= '0;
        end else if (exc_req) begin
            pc     <= EXC_VECTOR;
            pend_v <= 1'b0;
            pend_t <= '0;
        end else if (!stall) begin
            if (pend_v) begin
                pc     <= pend_t;
                pend_v <= 1'b0;
            end else if (taken && is_eret) begin
                pc     <= target;
            end else if (taken) begin
                pc     <= pc_plus4;
                pend_t <= target;
                pend_v <= 1'b1;
            end else begin
                pc     <= pc_plus4;
            end
        end
    end
`else
    logic unused_eret;

    assign unused_eret   = is_eret;
    assign taken         = raw_taken;
    assign in_delay_slot = 1'b0;
    assign link_addr     = pc + WIDTH'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (exc_req) begin
            pc <= EXC_VECTOR;
        end else if (!stall) begin
            pc <= taken ? target : pc_plus4;
        end
    end
`endif

endmodule

// File: tb/tb_npc_pipe.sv
// tb_npc_pipe: self-checking bench for npc_pipe (build with or without
// NPC_DELAY_SLOT_EN; the reference model follows the same switch).
module tb_npc_pipe;

`ifdef NPC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    localparam logic [31:0] R_PC = 32'h0000_3000;
    localparam logic [31:0] E_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [2:0]  npc_op;
    logic [2:0]  br_cond;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] epc;
    logic        exc_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] link_addr;
    logic        taken;
    logic        in_delay_slot;
    logic        misalign;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // reference model: fetch PC plus a queue of redirects awaiting their delay slot
    logic [31:0] m_pc;
    logic [31:0] pend_q[$];

    npc_pipe #(
        .WIDTH      (32),
        .RESET_PC   (R_PC),
        .EXC_VECTOR (E_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .npc_op        (npc_op),
        .br_cond       (br_cond),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .imm16         (imm16),
        .imm26         (imm26),
        .epc           (epc),
        .exc_req       (exc_req),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .link_addr     (link_addr),
        .taken         (taken),
        .in_delay_slot (in_delay_slot),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit cond_true(input logic [2:0] c, input logic [31:0] rs, input logic [31:0] rt);
        case (c)
            3'd0:    return rs == rt;
            3'd1:    return rs != rt;
            3'd2:    return $signed(rs) <= 0;
            3'd3:    return $signed(rs) > 0;
            3'd4:    return $signed(rs) < 0;
            3'd5:    return $signed(rs) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    // Called just after a rising edge: pulls reset, checks the async effect,
    // lets one edge pass in reset and releases it away from the edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pc", pc, R_PC);
        check("rst_ds", in_delay_slot, 1'b0);
        m_pc = R_PC;
        pend_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One instruction cycle: drive, check combinational outputs on the
    // falling edge against the model, then advance the model past the edge.
    task automatic step(input logic [2:0] a_op, input logic [2:0] a_cond,
                        input logic [31:0] a_rs, input logic [31:0] a_rt,
                        input logic [15:0] a_i16, input logic [25:0] a_i26,
                        input logic [31:0] a_epc, input logic a_exc, input logic a_stall);
        logic [31:0] tgt;
        bit          raw;
        bit          e_taken;
        bit          in_ds;
        npc_op  = a_op;
        br_cond = a_cond;
        rs_val  = a_rs;
        rt_val  = a_rt;
        imm16   = a_i16;
        imm26   = a_i26;
        epc     = a_epc;
        exc_req = a_exc;
        stall   = a_stall;

        in_ds = DS && (pend_q.size() != 0);
        case (a_op)
            3'd1:       begin tgt = m_pc + 32'd4 + 32'(int'($signed(a_i16)) * 4); raw = cond_true(a_cond, a_rs, a_rt); end
            3'd2, 3'd3: begin tgt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(a_i26) * 32'd4); raw = 1'b1; end
            3'd4:       begin tgt = a_rs;  raw = 1'b1; end
            3'd5:       begin tgt = a_epc; raw = 1'b1; end
            default:    begin tgt = m_pc + 32'd4; raw = 1'b0; end
        endcase
        e_taken = raw && !in_ds;

        @(negedge clk);
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("link_addr", link_addr, m_pc + (DS ? 32'd8 : 32'd4));
        check("taken", taken, e_taken);
        check("misalign", misalign, e_taken && (tgt % 4 != 0));
        check("in_delay_slot", in_delay_slot, in_ds);

        @(posedge clk);
        #1;
        if (a_exc) begin
            m_pc = E_PC;
            pend_q.delete();
        end else if (!a_stall) begin
            if (pend_q.size() != 0)            m_pc = pend_q.pop_front();
            else if (e_taken && a_op == 3'd5)  m_pc = tgt;
            else if (e_taken && DS) begin
                pend_q.push_back(tgt);
                m_pc = m_pc + 32'd4;
            end
            else if (e_taken)                  m_pc = tgt;
            else                               m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic seq();
        step(3'd0, 3'd0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; npc_op = '0; br_cond = '0; rs_val = '0; rt_val = '0;
        imm16 = '0; imm26 = '0; epc = '0; exc_req = 1'b0;
        m_pc = R_PC;
        repeat (2) @(posedge clk);
        #1;
        check("init_pc", pc, R_PC);
        check("init_ds", in_delay_slot, 1'b0);
        rst_n = 1'b1;

        // sequential flow
        repeat (3) seq();
        check("seq3_pc", pc, 32'h300C);

        // backward branch to itself
        do_reset();
        step(3'd1, 3'd0, 32'd5, 32'd5, 16'hFFFF, '0, '0, 1'b0, 1'b0);
        if (DS) begin
            check("br_ds_pc", pc, 32'h3004);
            check("br_ds_flag", in_delay_slot, 1'b1);
            seq();
        end
        check("br_pc", pc, 32'h3000);

        // JAL from 0x3010 to 0x3100, then stall across the delay slot
        do_reset();
        repeat (4) seq();
        check("pre_jal_pc", pc, 32'h3010);
        npc_op = 3'd3; imm26 = 26'h0000C40; stall = 1'b0; exc_req = 1'b0;
        #1;
        check("jal_link", link_addr, DS ? 32'h3018 : 32'h3014);
        step(3'd3, 3'd0, '0, '0, '0, 26'h0000C40, '0, 1'b0, 1'b0);
        repeat (4) step(3'd0, 3'd0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        check("stall_pc", pc, DS ? 32'h3014 : 32'h3100);
        if (DS) begin
            npc_op = 3'd1; br_cond = 3'd0; rs_val = 32'd7; rt_val = 32'd7; imm16 = 16'h0040; stall = 1'b0;
            #1;
            check("ds_br_ignored", taken, 1'b0);
            step(3'd1, 3'd0, 32'd7, 32'd7, 16'h0040, '0, '0, 1'b0, 1'b0);
            check("ds_arrive_pc", pc, 32'h3100);
        end

        // exception beats stall and a taken JR; ERET returns
        step(3'd4, 3'd0, 32'h0000_5000, '0, '0, '0, '0, 1'b1, 1'b1);
        check("exc_pc", pc, E_PC);
        check("exc_ds", in_delay_slot, 1'b0);
        step(3'd5, 3'd0, '0, '0, '0, '0, 32'h3024, 1'b0, 1'b0);
        check("eret_pc", pc, 32'h3024);

        // misaligned JR target is flagged but used
        npc_op = 3'd4; rs_val = 32'h3002;
        #1;
        check("jr_misalign", misalign, 1'b1);
        step(3'd4, 3'd0, 32'h3002, '0, '0, '0, '0, 1'b0, 1'b0);
        if (DS) seq();
        check("jr_pc", pc, 32'h3002);

        // BGEZ on a negative operand
        npc_op = 3'd1; br_cond = 3'd5; rs_val = 32'h8000_0000;
        #1;
        check("bgez_neg", taken, 1'b0);
        step(3'd1, 3'd5, 32'h8000_0000, '0, 16'h0010, '0, '0, 1'b0, 1'b0);

        // wrap at the top of the address space
        step(3'd4, 3'd0, 32'hFFFF_FFFC, '0, '0, '0, '0, 1'b0, 1'b0);
        if (DS) seq();
        check("top_pc", pc, 32'hFFFF_FFFC);
        seq();
        check("wrap_pc", pc, 32'h0000_0000);

        // reset while a redirect may be pending
        step(3'd4, 3'd0, 32'h3100, '0, '0, '0, '0, 1'b0, 1'b0);
        do_reset();
        seq();
        check("post_rst_pc", pc, 32'h3004);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rs;
            logic [31:0] rt;
            int unsigned sel;
            sel = $urandom_range(0, 3);
            rs  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'd5 : (sel == 2) ? 32'h8000_0000 : $urandom();
            rt  = ($urandom_range(0, 1) == 1) ? rs : $urandom();
            if ($urandom_range(0, 63) == 0)
                do_reset();
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rs, rt,
                 16'($urandom()), 26'($urandom()), $urandom(),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
